// File: rtl/uart_alu_interface.sv
// Byte-stream front end for the ALU. Three received bytes form one transaction:
// operand A, operand B, then opcode. The ALU result is latched and handed to the
// UART transmitter with a one-cycle start pulse; the block then waits for the
// transmitter's done pulse before accepting the next transaction.
module uart_alu_interface #(
    parameter int unsigned DATA_WIDTH = 8,
    parameter int unsigned OP_WIDTH   = 6
) (
    input  logic                  i_clock,
    input  logic                  i_reset,
    input  logic                  i_rx_done,
    input  logic [DATA_WIDTH-1:0] i_rx_data,
    input  logic [DATA_WIDTH-1:0] i_alu_result,
    input  logic                  i_tx_done,
    output logic [DATA_WIDTH-1:0] o_alu_a,
    output logic [DATA_WIDTH-1:0] o_alu_b,
    output logic [OP_WIDTH-1:0]   o_alu_op,
    output logic                  o_tx_start,
    output logic [DATA_WIDTH-1:0] o_tx_data,
    output logic                  o_busy,
    output logic                  o_overrun
);

    typedef enum logic [5:0] {
        StWaitA  = 6'b000001,
        StWaitB  = 6'b000010,
        StWaitOp = 6'b000100,
        StExec   = 6'b001000,
        StSend   = 6'b010000,
        StWaitTx = 6'b100000
    } state_e;

    state_e                state_q, state_d;
    logic [DATA_WIDTH-1:0] alu_a_q, alu_a_d;
    logic [DATA_WIDTH-1:0] alu_b_q, alu_b_d;
    logic [OP_WIDTH-1:0]   alu_op_q, alu_op_d;
    logic [DATA_WIDTH-1:0] tx_data_q, tx_data_d;
    logic                  overrun_q, overrun_d;

    // Next-state and register-update logic for the transaction sequencer.
    always_comb begin
        state_d   = state_q;
        alu_a_d   = alu_a_q;
        alu_b_d   = alu_b_q;
        alu_op_d  = alu_op_q;
        tx_data_d = tx_data_q;
        overrun_d = overrun_q;

        unique case (state_q)
            StWaitA: begin
                if (i_rx_done) begin
                    alu_a_d = i_rx_data;
                    state_d = StWaitB;
                end
            end
            StWaitB: begin
                if (i_rx_done) begin
                    alu_b_d = i_rx_data;
                    state_d = StWaitOp;
                end
            end
            StWaitOp: begin
                if (i_rx_done) begin
                    alu_op_d = i_rx_data[OP_WIDTH-1:0];
                    state_d  = StExec;
                end
            end
            StExec: begin
                // Operands/opcode have been stable for this whole cycle.
                tx_data_d = i_alu_result;
                state_d   = StSend;
                if (i_rx_done) overrun_d = 1'b1;
            end
            StSend: begin
                state_d = StWaitTx;
                if (i_rx_done) overrun_d = 1'b1;
            end
            StWaitTx: begin
                if (i_tx_done) begin
                    state_d = StWaitA;
                    // A byte arriving together with tx_done starts the next transaction.
                    if (i_rx_done) begin
                        alu_a_d = i_rx_data;
                        state_d = StWaitB;
                    end
                end else if (i_rx_done) begin
                    overrun_d = 1'b1;
                end
            end
            default: state_d = StWaitA;
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_q   <= StWaitA;
            alu_a_q   <= '0;
            alu_b_q   <= '0;
            alu_op_q  <= '0;
            tx_data_q <= '0;
            overrun_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            alu_a_q   <= alu_a_d;
            alu_b_q   <= alu_b_d;
            alu_op_q  <= alu_op_d;
            tx_data_q <= tx_data_d;
            overrun_q <= overrun_d;
        end
    end

    assign o_alu_a    = alu_a_q;
    assign o_alu_b    = alu_b_q;
    assign o_alu_op   = alu_op_q;
    assign o_tx_data  = tx_data_q;
    assign o_overrun  = overrun_q;
    assign o_tx_start = (state_q == StSend);
    assign o_busy     = (state_q == StExec) || (state_q == StSend) || (state_q == StWaitTx);

endmodule

// File: tb/tb_uart_alu_interface.sv
// Bench for uart_alu_interface: directed byte sequences, a small ALU model, and a
// scoreboard of expected transmit bytes checked by an independent monitor.
module tb_uart_alu_interface;

    localparam int unsigned DW = 8;
    localparam int unsigned OW = 6;

    logic          i_clock = 1'b0;
    logic          i_reset = 1'b1;
    logic          i_rx_done = 1'b0;
    logic [DW-1:0] i_rx_data = '0;
    logic [DW-1:0] i_alu_result;
    logic          i_tx_done = 1'b0;
    logic [DW-1:0] o_alu_a;
    logic [DW-1:0] o_alu_b;
    logic [OW-1:0] o_alu_op;
    logic          o_tx_start;
    logic [DW-1:0] o_tx_data;
    logic          o_busy;
    logic          o_overrun;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;

    typedef struct {
        logic [DW-1:0] data;
        int            at_cyc;
    } exp_t;
    exp_t sb_q[$];

    uart_alu_interface #(.DATA_WIDTH(DW), .OP_WIDTH(OW)) dut (
        .i_clock     (i_clock),
        .i_reset     (i_reset),
        .i_rx_done   (i_rx_done),
        .i_rx_data   (i_rx_data),
        .i_alu_result(i_alu_result),
        .i_tx_done   (i_tx_done),
        .o_alu_a     (o_alu_a),
        .o_alu_b     (o_alu_b),
        .o_alu_op    (o_alu_op),
        .o_tx_start  (o_tx_start),
        .o_tx_data   (o_tx_data),
        .o_busy      (o_busy),
        .o_overrun   (o_overrun)
    );

    always #5 i_clock = ~i_clock;
    always @(posedge i_clock) cyc <= cyc + 1;

    // ALU model: ADD, SUB, AND, truncated to the data width.
    always_comb begin
        i_alu_result = '0;
        case (o_alu_op)
            6'h20: i_alu_result = o_alu_a + o_alu_b;
            6'h22: i_alu_result = o_alu_a - o_alu_b;
            6'h24: i_alu_result = o_alu_a & o_alu_b;
            default: i_alu_result = '0;
        endcase
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Monitor: every start pulse must match the oldest expected byte and its cycle.
    always @(negedge i_clock) begin
        if (o_tx_start) begin
            if (sb_q.size() == 0) begin
                n_cmp++;
                n_err++;
                $display("FAIL unexpected_tx_start: got data 0x%0h at cycle %0d, expected none",
                         o_tx_data, cyc);
            end else begin
                exp_t e;
                e = sb_q.pop_front();
                check("tx_data", 32'(o_tx_data), 32'(e.data));
                check("tx_start_cycle", 32'(cyc), 32'(e.at_cyc));
            end
        end
    end

    task automatic send_byte(input logic [DW-1:0] b);
        @(negedge i_clock);
        i_rx_done = 1'b1;
        i_rx_data = b;
        @(negedge i_clock);
        i_rx_done = 1'b0;
    endtask

    // Sends three bytes and queues the expected result two cycles after the op byte.
    task automatic send_txn(input logic [DW-1:0] a, input logic [DW-1:0] b,
                            input logic [DW-1:0] op, input logic [DW-1:0] exp);
        exp_t e;
        send_byte(a);
        send_byte(b);
        send_byte(op);
        e.data   = exp;
        e.at_cyc = cyc + 1;
        sb_q.push_back(e);
    endtask

    // Waits for the start pulse, then returns one cycle later (in WAIT_TX).
    task automatic wait_start(input string name);
        bit seen = 1'b0;
        for (int i = 0; i < 20; i++) begin
            @(negedge i_clock);
            if (o_tx_start) begin
                seen = 1'b1;
                break;
            end
        end
        check({name, "_start_seen"}, 32'(seen), 32'd1);
        @(negedge i_clock);
        check({name, "_busy_wait_tx"}, 32'(o_busy), 32'd1);
    endtask

    task automatic tx_ack(input string name);
        i_tx_done = 1'b1;
        @(negedge i_clock);
        i_tx_done = 1'b0;
        check({name, "_busy_after_ack"}, 32'(o_busy), 32'd0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge i_clock);
        check("rst_alu_a", 32'(o_alu_a), 32'h0);
        check("rst_alu_b", 32'(o_alu_b), 32'h0);
        check("rst_alu_op", 32'(o_alu_op), 32'h0);
        check("rst_tx_start", 32'(o_tx_start), 32'h0);
        check("rst_tx_data", 32'(o_tx_data), 32'h0);
        check("rst_busy", 32'(o_busy), 32'h0);
        check("rst_overrun", 32'(o_overrun), 32'h0);
        i_reset = 1'b0;

        // 1: ADD 5+3
        send_txn(8'h05, 8'h03, 8'h20, 8'h08);
        check("t1_alu_a", 32'(o_alu_a), 32'h05);
        check("t1_alu_b", 32'(o_alu_b), 32'h03);
        check("t1_alu_op", 32'(o_alu_op), 32'h20);
        check("t1_busy_exec", 32'(o_busy), 32'd1);
        wait_start("t1");
        repeat (3) @(negedge i_clock);
        check("t1_busy_hold", 32'(o_busy), 32'd1);
        check("t1_tx_data_stable", 32'(o_tx_data), 32'h08);
        tx_ack("t1");

        // 2: SUB with wrap, ADD with carry-out truncated
        send_txn(8'h03, 8'h05, 8'h22, 8'hFE);
        wait_start("t2a");
        tx_ack("t2a");
        send_txn(8'hFF, 8'h02, 8'h20, 8'h01);
        wait_start("t2b");
        tx_ack("t2b");

        // 3: opcode upper bits dropped
        send_txn(8'hF0, 8'h3C, 8'hE4, 8'h30);
        check("t3_alu_op", 32'(o_alu_op), 32'h24);
        wait_start("t3");
        tx_ack("t3");

        // 5: rx_done together with tx_done starts the next transaction
        send_txn(8'h10, 8'h04, 8'h24, 8'h00);
        wait_start("t5");
        i_tx_done = 1'b1;
        i_rx_done = 1'b1;
        i_rx_data = 8'h09;
        @(negedge i_clock);
        i_tx_done = 1'b0;
        i_rx_done = 1'b0;
        check("t5_alu_a", 32'(o_alu_a), 32'h09);
        check("t5_busy", 32'(o_busy), 32'd0);
        check("t5_overrun", 32'(o_overrun), 32'd0);
        begin
            exp_t e;
            send_byte(8'h01);
            send_byte(8'h20);
            e.data   = 8'h0A;
            e.at_cyc = cyc + 1;
            sb_q.push_back(e);
        end
        wait_start("t5b");
        tx_ack("t5b");

        // 4: byte in WAIT_TX without tx_done is dropped and sets sticky overrun
        send_txn(8'h05, 8'h03, 8'h20, 8'h08);
        wait_start("t4");
        send_byte(8'h77);
        check("t4_overrun_set", 32'(o_overrun), 32'd1);
        check("t4_alu_a_kept", 32'(o_alu_a), 32'h05);
        check("t4_busy", 32'(o_busy), 32'd1);
        tx_ack("t4");
        send_txn(8'h01, 8'h01, 8'h20, 8'h02);
        wait_start("t4b");
        tx_ack("t4b");
        check("t4_overrun_sticky", 32'(o_overrun), 32'd1);

        // 6: reset mid-transaction discards partial operands
        send_byte(8'h05);
        send_byte(8'h03);
        check("t6_pre_a", 32'(o_alu_a), 32'h05);
        check("t6_pre_b", 32'(o_alu_b), 32'h03);
        i_reset = 1'b1;
        @(negedge i_clock);
        i_reset = 1'b0;
        check("t6_alu_a", 32'(o_alu_a), 32'h0);
        check("t6_alu_b", 32'(o_alu_b), 32'h0);
        check("t6_alu_op", 32'(o_alu_op), 32'h0);
        check("t6_tx_data", 32'(o_tx_data), 32'h0);
        check("t6_busy", 32'(o_busy), 32'd0);
        check("t6_overrun", 32'(o_overrun), 32'd0);
        send_txn(8'h02, 8'h02, 8'h20, 8'h04);
        wait_start("t6");
        tx_ack("t6");

        repeat (5) @(negedge i_clock);
        check("sb_empty", 32'(sb_q.size()), 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
